fft_bin_serializer: RTL

- Output-side companion to the parallel `fft` core.
- Captures one complete N-bin frame (`X_real`/`X_im` arrays, Q(W-8).8 fixed point) in a single cycle.
- Streams the bins out one per beat over a valid/ready interface for downstream consumers (UART/DMA/magnitude logic).
- Optionally undoes bit-reversed bin ordering so the stream is always in natural index order.

---
 rtl/fft_bin_serializer.sv | 108 ++++++++++
 1 files changed

// File: rtl/fft_bin_serializer.sv
// Captures one full FFT frame in a single cycle and streams its bins out one per beat
// over valid/ready, optionally undoing bit-reversed bin order so output is always natural order.
module fft_bin_serializer #(
    parameter int N      = 16,
    parameter int W      = 16,
    parameter bit BITREV = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic signed [W-1:0]     X_real [N],
    input  logic signed [W-1:0]     X_im [N],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W-1:0]     out_real,
    output logic signed [W-1:0]     out_im,
    output logic [$clog2(N)-1:0]    out_index,
    output logic                    out_last
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state;
    state_t              state_next;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       rd_idx;
    logic signed [W-1:0] bin_real [N];
    logic signed [W-1:0] bin_im [N];
    logic                at_last;
    logic                transfer;
    logic                capture;

    function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] x);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < IW; i++) begin
            r[i] = x[IW-1-i];
        end
        return r;
    endfunction

    assign at_last  = (idx == LAST_IDX);
    assign transfer = out_valid & out_ready;
    assign capture  = frame_valid & frame_ready;
    assign rd_idx   = BITREV ? bitrev(idx) : idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A last-beat transfer with a new frame waiting stays in STREAM for zero-bubble back-to-back frames.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (frame_valid) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (transfer && at_last && !frame_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_ready = (state == IDLE) || ((state == STREAM) && at_last && out_ready);
        out_valid   = (state == STREAM);
        out_last    = 1'b0;
        out_index   = '0;
        out_real    = '0;
        out_im      = '0;
        if (state == STREAM) begin
            out_last  = at_last;
            out_index = idx;
            out_real  = bin_real[rd_idx];
            out_im    = bin_im[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            for (int i = 0; i < N; i++) begin
                bin_real[i] <= '0;
                bin_im[i]   <= '0;
            end
        end else if (capture) begin
            idx      <= '0;
            bin_real <= X_real;
            bin_im   <= X_im;
        end else if (transfer && !at_last) begin
            idx <= idx + IW'(1);
        end
    end

endmodule
